// File: rtl/cmsdk_ahb_arb_pkg.sv
// Shared constants for the two-master SRAM arbiter: AHB transfer types and
// the encoding of which master currently owns the slave data phase.
package cmsdk_ahb_arb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_e;

endpackage

// File: rtl/cmsdk_ahb_arb_hold_reg.sv
// Per-master address-phase hold register: captures a stalled request and
// presents either the held or the live attributes to the arbiter.
module cmsdk_ahb_arb_hold_reg
  import cmsdk_ahb_arb_pkg::*;
#(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic          clear_i,
  input  logic [AW-1:0] haddr_i,
  input  logic [2:0]    hsize_i,
  input  logic          hwrite_i,
  output logic          pend_valid_o,
  output logic [AW-1:0] haddr_o,
  output logic [2:0]    hsize_o,
  output logic          hwrite_o
);

  logic          pend_q;
  logic [AW-1:0] haddr_q;
  logic [2:0]    hsize_q;
  logic          hwrite_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q   <= 1'b0;
      haddr_q  <= '0;
      hsize_q  <= '0;
      hwrite_q <= 1'b0;
    end else if (load_i) begin
      pend_q   <= 1'b1;
      haddr_q  <= haddr_i;
      hsize_q  <= hsize_i;
      hwrite_q <= hwrite_i;
    end else if (clear_i) begin
      pend_q   <= 1'b0;
    end
  end

  assign pend_valid_o = pend_q;
  assign haddr_o      = pend_q ? haddr_q  : haddr_i;
  assign hsize_o      = pend_q ? hsize_q  : hsize_i;
  assign hwrite_o     = pend_q ? hwrite_q : hwrite_i;

endmodule

// File: rtl/cmsdk_ahb_sram_arbiter.sv
// Two-master AHB-Lite arbiter in front of the shared SRAM slave port.
// Fixed M0 priority by default; define ARB_ROUND_ROBIN_EN for alternating priority.
module cmsdk_ahb_sram_arbiter
  import cmsdk_ahb_arb_pkg::*;
#(
  parameter int AW = 16
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          m0_hsel,
  input  logic [AW-1:0] m0_haddr,
  input  logic [1:0]    m0_htrans,
  input  logic [2:0]    m0_hsize,
  input  logic          m0_hwrite,
  input  logic [31:0]   m0_hwdata,
  input  logic          m0_hready,
  output logic          m0_hreadyout,
  output logic [31:0]   m0_hrdata,
  output logic          m0_hresp,
  input  logic          m1_hsel,
  input  logic [AW-1:0] m1_haddr,
  input  logic [1:0]    m1_htrans,
  input  logic [2:0]    m1_hsize,
  input  logic          m1_hwrite,
  input  logic [31:0]   m1_hwdata,
  input  logic          m1_hready,
  output logic          m1_hreadyout,
  output logic [31:0]   m1_hrdata,
  output logic          m1_hresp,
  output logic          s_hsel,
  output logic [AW-1:0] s_haddr,
  output logic [1:0]    s_htrans,
  output logic [2:0]    s_hsize,
  output logic          s_hwrite,
  output logic [31:0]   s_hwdata,
  output logic          s_hready,
  input  logic          s_hreadyout,
  input  logic [31:0]   s_hrdata,
  input  logic          s_hresp
);

  logic          live0, live1, pend0, pend1, req0, req1;
  logic          win0, win1, issue;
  logic [AW-1:0] addr0, addr1;
  logic [2:0]    size0, size1;
  logic          write0, write1;
  owner_e        dp_own_q, dp_own_d;

  assign live0 = m0_hsel & m0_hready & ((m0_htrans == HTRANS_NONSEQ) | (m0_htrans == HTRANS_SEQ));
  assign live1 = m1_hsel & m1_hready & ((m1_htrans == HTRANS_NONSEQ) | (m1_htrans == HTRANS_SEQ));
  assign req0  = pend0 | live0;
  assign req1  = pend1 | live1;

  assign s_hready = (dp_own_q == OWN_NONE) ? 1'b1 : s_hreadyout;
  assign issue    = s_hready & (req0 | req1);

`ifdef ARB_ROUND_ROBIN_EN
  // Set means M1 was granted last, so M0 is preferred on the next contention.
  logic last_grant_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)   last_grant_q <= 1'b1;
    else if (issue) last_grant_q <= win1;
  end

  assign win0 = req0 & (~req1 | last_grant_q);
`else
  assign win0 = req0;
`endif
  assign win1 = req1 & ~win0;

  cmsdk_ahb_arb_hold_reg #(.AW(AW)) u_hold0 (
    .clk          (HCLK),
    .rst_n        (HRESETn),
    .load_i       (live0 & ~pend0 & ~(issue & win0)),
    .clear_i      (pend0 & issue & win0),
    .haddr_i      (m0_haddr),
    .hsize_i      (m0_hsize),
    .hwrite_i     (m0_hwrite),
    .pend_valid_o (pend0),
    .haddr_o      (addr0),
    .hsize_o      (size0),
    .hwrite_o     (write0)
  );

  cmsdk_ahb_arb_hold_reg #(.AW(AW)) u_hold1 (
    .clk          (HCLK),
    .rst_n        (HRESETn),
    .load_i       (live1 & ~pend1 & ~(issue & win1)),
    .clear_i      (pend1 & issue & win1),
    .haddr_i      (m1_haddr),
    .hsize_i      (m1_hsize),
    .hwrite_i     (m1_hwrite),
    .pend_valid_o (pend1),
    .haddr_o      (addr1),
    .hsize_o      (size1),
    .hwrite_o     (write1)
  );

  // SEQ is always re-issued as NONSEQ since the burst context is lost across masters.
  assign s_hsel   = issue;
  assign s_htrans = issue ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign s_haddr  = issue ? (win0 ? addr0 : addr1) : '0;
  assign s_hsize  = issue ? (win0 ? size0 : size1) : '0;
  assign s_hwrite = issue & (win0 ? write0 : write1);

  always_comb begin
    dp_own_d = dp_own_q;
    if (s_hready) dp_own_d = issue ? (win0 ? OWN_M0 : OWN_M1) : OWN_NONE;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) dp_own_q <= OWN_NONE;
    else          dp_own_q <= dp_own_d;
  end

  always_comb begin
    s_hwdata = '0;
    case (dp_own_q)
      OWN_M0:  s_hwdata = m0_hwdata;
      OWN_M1:  s_hwdata = m1_hwdata;
      default: s_hwdata = '0;
    endcase
  end

  assign m0_hreadyout = (dp_own_q == OWN_M0) ? s_hreadyout : ~pend0;
  assign m1_hreadyout = (dp_own_q == OWN_M1) ? s_hreadyout : ~pend1;
  assign m0_hresp     = (dp_own_q == OWN_M0) & s_hresp;
  assign m1_hresp     = (dp_own_q == OWN_M1) & s_hresp;
  assign m0_hrdata    = s_hrdata;
  assign m1_hrdata    = s_hrdata;

endmodule

// File: tb/tb_cmsdk_ahb_sram_arbiter.sv
// Directed table-driven bench for cmsdk_ahb_sram_arbiter; the bench acts as the
// SRAM by driving its response signals row by row.
module tb_cmsdk_ahb_sram_arbiter;

  localparam logic [1:0] NS = 2'b10;
  localparam logic [1:0] SQ = 2'b11;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        m0_hsel, m1_hsel;
  logic [15:0] m0_haddr, m1_haddr;
  logic [1:0]  m0_htrans, m1_htrans;
  logic [2:0]  m0_hsize, m1_hsize;
  logic        m0_hwrite, m1_hwrite;
  logic [31:0] m0_hwdata, m1_hwdata;
  logic        m0_hready, m1_hready;
  logic        m0_hreadyout, m1_hreadyout;
  logic [31:0] m0_hrdata, m1_hrdata;
  logic        m0_hresp, m1_hresp;
  logic        s_hsel;
  logic [15:0] s_haddr;
  logic [1:0]  s_htrans;
  logic [2:0]  s_hsize;
  logic        s_hwrite;
  logic [31:0] s_hwdata;
  logic        s_hready;
  logic        s_hreadyout;
  logic [31:0] s_hrdata;
  logic        s_hresp;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        m0Sel;
    logic [1:0]  m0Trans;
    logic [15:0] m0Addr;
    logic        m0Write;
    logic [31:0] m0Wdata;
    logic        m1Sel;
    logic [1:0]  m1Trans;
    logic [15:0] m1Addr;
    logic        m1Write;
    logic [31:0] m1Wdata;
    logic        sReadyOut;
    logic [31:0] sRdata;
    logic        sResp;
    logic        eSel;
    logic [1:0]  eTrans;
    logic [15:0] eAddr;
    logic        eWrite;
    logic [31:0] eWdata;
    logic        eSReady;
    logic        eM0Rdy;
    logic        eM1Rdy;
    logic        eM0Resp;
    logic        eM1Resp;
  } vec_t;

  vec_t vecs[13];

  always #5 HCLK = ~HCLK;

  // Each master segment has only this slave, so its HREADY is our HREADYOUT.
  assign m0_hready = m0_hreadyout;
  assign m1_hready = m1_hreadyout;

  cmsdk_ahb_sram_arbiter #(.AW(16)) dut (
    .HCLK         (HCLK),
    .HRESETn      (HRESETn),
    .m0_hsel      (m0_hsel),
    .m0_haddr     (m0_haddr),
    .m0_htrans    (m0_htrans),
    .m0_hsize     (m0_hsize),
    .m0_hwrite    (m0_hwrite),
    .m0_hwdata    (m0_hwdata),
    .m0_hready    (m0_hready),
    .m0_hreadyout (m0_hreadyout),
    .m0_hrdata    (m0_hrdata),
    .m0_hresp     (m0_hresp),
    .m1_hsel      (m1_hsel),
    .m1_haddr     (m1_haddr),
    .m1_htrans    (m1_htrans),
    .m1_hsize     (m1_hsize),
    .m1_hwrite    (m1_hwrite),
    .m1_hwdata    (m1_hwdata),
    .m1_hready    (m1_hready),
    .m1_hreadyout (m1_hreadyout),
    .m1_hrdata    (m1_hrdata),
    .m1_hresp     (m1_hresp),
    .s_hsel       (s_hsel),
    .s_haddr      (s_haddr),
    .s_htrans     (s_htrans),
    .s_hsize      (s_hsize),
    .s_hwrite     (s_hwrite),
    .s_hwdata     (s_hwdata),
    .s_hready     (s_hready),
    .s_hreadyout  (s_hreadyout),
    .s_hrdata     (s_hrdata),
    .s_hresp      (s_hresp)
  );

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic driveMasters(input logic s0, input logic [1:0] t0, input logic [15:0] a0,
                              input logic w0, input logic [31:0] d0,
                              input logic s1, input logic [1:0] t1, input logic [15:0] a1,
                              input logic w1, input logic [31:0] d1);
    m0_hsel = s0; m0_htrans = t0; m0_haddr = a0; m0_hwrite = w0; m0_hwdata = d0;
    m1_hsel = s1; m1_htrans = t1; m1_haddr = a1; m1_hwrite = w1; m1_hwdata = d1;
  endtask

  task automatic applyStimulus(input vec_t v);
    driveMasters(v.m0Sel, v.m0Trans, v.m0Addr, v.m0Write, v.m0Wdata,
                 v.m1Sel, v.m1Trans, v.m1Addr, v.m1Write, v.m1Wdata);
    s_hreadyout = v.sReadyOut;
    s_hrdata    = v.sRdata;
    s_hresp     = v.sResp;
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    string p;
    p = $sformatf("row%0d.", idx);
    checkVal({p, "s_hsel"},       32'(s_hsel),       32'(v.eSel));
    checkVal({p, "s_htrans"},     32'(s_htrans),     32'(v.eTrans));
    checkVal({p, "s_haddr"},      32'(s_haddr),      32'(v.eAddr));
    checkVal({p, "s_hsize"},      32'(s_hsize),      v.eSel ? 32'd2 : 32'd0);
    checkVal({p, "s_hwrite"},     32'(s_hwrite),     32'(v.eWrite));
    checkVal({p, "s_hwdata"},     s_hwdata,          v.eWdata);
    checkVal({p, "s_hready"},     32'(s_hready),     32'(v.eSReady));
    checkVal({p, "m0_hreadyout"}, 32'(m0_hreadyout), 32'(v.eM0Rdy));
    checkVal({p, "m1_hreadyout"}, 32'(m1_hreadyout), 32'(v.eM1Rdy));
    checkVal({p, "m0_hresp"},     32'(m0_hresp),     32'(v.eM0Resp));
    checkVal({p, "m1_hresp"},     32'(m1_hresp),     32'(v.eM1Resp));
    checkVal({p, "m0_hrdata"},    m0_hrdata,         v.sRdata);
    checkVal({p, "m1_hrdata"},    m1_hrdata,         v.sRdata);
  endtask

  task automatic nextCycle();
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    logic [15:0] expAddr;

    // Row layout: m0{sel,trans,addr,write,wdata} m1{...} sram{readyout,rdata,resp} expected{sel,trans,addr,write,wdata,s_hready,m0rdy,m1rdy,m0resp,m1resp}
    vecs[0]  = '{0,0,16'h0000,0,32'h0,          0,0,16'h0000,0,32'h0,          1,32'h0,0,          0,0,16'h0000,0,32'h0,        1,1,1,0,0};
    vecs[1]  = '{1,NS,16'h0040,0,32'h0,         0,0,16'h0000,0,32'h0,          1,32'h0,0,          1,NS,16'h0040,0,32'h0,       1,1,1,0,0};
    vecs[2]  = '{0,0,16'h0000,0,32'h0,          0,0,16'h0000,0,32'h0,          1,32'hCAFE0001,0,   0,0,16'h0000,0,32'h0,        1,1,1,0,0};
    vecs[3]  = '{0,0,16'h0000,0,32'h0,          1,SQ,16'h0044,0,32'h0,         1,32'h0,0,          1,NS,16'h0044,0,32'h0,       1,1,1,0,0};
    vecs[4]  = '{0,0,16'h0000,0,32'h0,          0,0,16'h0000,0,32'h0,          1,32'hA5A50044,0,   0,0,16'h0000,0,32'h0,        1,1,1,0,0};
    vecs[5]  = '{1,NS,16'h0010,1,32'h0,         1,NS,16'h0020,1,32'h0,         1,32'h0,0,          1,NS,16'h0010,1,32'h0,       1,1,1,0,0};
    vecs[6]  = '{0,0,16'h0000,0,32'h11111111,   0,0,16'h0000,0,32'h22222222,   1,32'h0,0,          1,NS,16'h0020,1,32'h11111111,1,1,0,0,0};
    vecs[7]  = '{0,0,16'h0000,0,32'h0,          0,0,16'h0000,0,32'h22222222,   1,32'h0,0,          0,0,16'h0000,0,32'h22222222,1,1,1,0,0};
    vecs[8]  = '{1,NS,16'h0010,1,32'h0,         1,NS,16'h0020,1,32'h0,         1,32'h0,0,          1,NS,16'h0010,1,32'h0,       1,1,1,0,0};
    vecs[9]  = '{0,0,16'h0000,0,32'h11111111,   0,0,16'h0000,0,32'h22222222,   0,32'h0,0,          0,0,16'h0000,0,32'h11111111,0,0,0,0,0};
    vecs[10] = '{0,0,16'h0000,0,32'h11111111,   0,0,16'h0000,0,32'h22222222,   0,32'h0,0,          0,0,16'h0000,0,32'h11111111,0,0,0,0,0};
    vecs[11] = '{0,0,16'h0000,0,32'h11111111,   0,0,16'h0000,0,32'h22222222,   1,32'h0,0,          1,NS,16'h0020,1,32'h11111111,1,1,0,0,0};
    vecs[12] = '{0,0,16'h0000,0,32'h0,          0,0,16'h0000,0,32'h22222222,   1,32'h0,0,          0,0,16'h0000,0,32'h22222222,1,1,1,0,0};

    m0_hsize = 3'b010;
    m1_hsize = 3'b010;
    driveMasters(0, 0, 16'h0, 0, 32'h0, 0, 0, 16'h0, 0, 32'h0);
    s_hreadyout = 1'b1;
    s_hrdata    = 32'h0;
    s_hresp     = 1'b0;
    HRESETn     = 1'b0;
    repeat (2) @(posedge HCLK);
    #1 HRESETn = 1'b1;

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i]);
      @(negedge HCLK);
      checkOutput(vecs[i], i);
      nextCycle();
    end

    // ERROR on M1 while M0 queues behind it.
    driveMasters(0, 0, 16'h0, 0, 32'h0, 1, NS, 16'h0030, 0, 32'h0);
    s_hreadyout = 1'b1; s_hresp = 1'b0;
    @(negedge HCLK);
    checkVal("errA.s_hsel", 32'(s_hsel), 32'd1);
    checkVal("errA.s_haddr", 32'(s_haddr), 32'h0030);
    nextCycle();
    driveMasters(1, NS, 16'h0050, 0, 32'h0, 0, 0, 16'h0, 0, 32'h0);
    s_hreadyout = 1'b0; s_hresp = 1'b1;
    @(negedge HCLK);
    checkVal("errB.m1_hresp", 32'(m1_hresp), 32'd1);
    checkVal("errB.m1_hreadyout", 32'(m1_hreadyout), 32'd0);
    checkVal("errB.m0_hresp", 32'(m0_hresp), 32'd0);
    checkVal("errB.s_hsel", 32'(s_hsel), 32'd0);
    nextCycle();
    driveMasters(0, 0, 16'h0, 0, 32'h0, 0, 0, 16'h0, 0, 32'h0);
    s_hreadyout = 1'b1; s_hresp = 1'b1;
    @(negedge HCLK);
    checkVal("errC.m1_hresp", 32'(m1_hresp), 32'd1);
    checkVal("errC.m1_hreadyout", 32'(m1_hreadyout), 32'd1);
    checkVal("errC.m0_hresp", 32'(m0_hresp), 32'd0);
    checkVal("errC.m0_hreadyout", 32'(m0_hreadyout), 32'd0);
    checkVal("errC.s_hsel", 32'(s_hsel), 32'd1);
    checkVal("errC.s_haddr", 32'(s_haddr), 32'h0050);
    nextCycle();
    s_hresp = 1'b0; s_hrdata = 32'hBEEF0050;
    @(negedge HCLK);
    checkVal("errD.m0_hreadyout", 32'(m0_hreadyout), 32'd1);
    checkVal("errD.m0_hresp", 32'(m0_hresp), 32'd0);
    checkVal("errD.m1_hresp", 32'(m1_hresp), 32'd0);
    checkVal("errD.m0_hrdata", m0_hrdata, 32'hBEEF0050);
    nextCycle();

    // Asynchronous reset with one transfer in flight and one pending.
    driveMasters(1, NS, 16'h0060, 1, 32'h0, 1, NS, 16'h0070, 1, 32'h0);
    @(negedge HCLK);
    checkVal("rstE.s_hsel", 32'(s_hsel), 32'd1);
    nextCycle();
    driveMasters(0, 0, 16'h0, 0, 32'h66666666, 0, 0, 16'h0, 0, 32'h77777777);
    s_hreadyout = 1'b0; s_hrdata = 32'h12345678;
    @(negedge HCLK);
    checkVal("rstF.m0_hreadyout", 32'(m0_hreadyout), 32'd0);
    checkVal("rstF.m1_hreadyout", 32'(m1_hreadyout), 32'd0);
    #1 HRESETn = 1'b0;
    #1;
    checkVal("rst.s_hsel", 32'(s_hsel), 32'd0);
    checkVal("rst.s_htrans", 32'(s_htrans), 32'd0);
    checkVal("rst.s_haddr", 32'(s_haddr), 32'd0);
    checkVal("rst.s_hsize", 32'(s_hsize), 32'd0);
    checkVal("rst.s_hwrite", 32'(s_hwrite), 32'd0);
    checkVal("rst.s_hwdata", s_hwdata, 32'd0);
    checkVal("rst.s_hready", 32'(s_hready), 32'd1);
    checkVal("rst.m0_hreadyout", 32'(m0_hreadyout), 32'd1);
    checkVal("rst.m1_hreadyout", 32'(m1_hreadyout), 32'd1);
    checkVal("rst.m0_hresp", 32'(m0_hresp), 32'd0);
    checkVal("rst.m1_hresp", 32'(m1_hresp), 32'd0);
    checkVal("rst.m0_hrdata", m0_hrdata, 32'h12345678);
    checkVal("rst.m1_hrdata", m1_hrdata, 32'h12345678);
    repeat (2) @(posedge HCLK);
    #1 HRESETn = 1'b1;

    // Both masters request continuously; record who gets each slave slot.
    driveMasters(1, NS, 16'h0100, 0, 32'h0, 1, NS, 16'h0200, 0, 32'h0);
    s_hreadyout = 1'b1; s_hrdata = 32'h0;
    for (int k = 0; k < 8; k++) begin
      @(negedge HCLK);
`ifdef ARB_ROUND_ROBIN_EN
      expAddr = (k % 2 == 0) ? 16'h0100 : 16'h0200;
`else
      expAddr = 16'h0100;
`endif
      checkVal($sformatf("grant%0d.s_hsel", k), 32'(s_hsel), 32'd1);
      checkVal($sformatf("grant%0d.s_haddr", k), 32'(s_haddr), 32'(expAddr));
      nextCycle();
    end
    driveMasters(0, 0, 16'h0, 0, 32'h0, 0, 0, 16'h0, 0, 32'h0);
    repeat (2) @(posedge HCLK);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
